// File: rtl/prbs_tx_sequencer.sv
// prbs_tx_sequencer
// PRBS9 (x^9+x^5+1) transmit source plus the sync/BER control sequencer
// that drives the receive-side BER counter. All state advances one step per
// baud strobe (i_ctrl); reset or a low i_en_tx act on any clock.
//
// Handshake with the BER counter: there is no ready/valid pair. Every output
// is decoded from registers, so it is stable for a whole strobe interval and
// the counter samples it on its own strobe cycle (the same cycle as ours).
// o_state exposes the FSM for checkers: 0 = IDLE, 1 = SYNC, 2 = BER.
module prbs_tx_sequencer #(
  parameter logic [8:0] SEED            = 9'h1AA,
  parameter int         PRBS_MAX_CYCLES = 511
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_en_tx,
  input  logic       i_ctrl,
  input  logic       i_start,
  input  logic       i_stop,
  output logic       o_tx_bit,
  output logic       o_new_bit_from_prbs,
  output logic       o_synchro_en,
  output logic       o_prbs_cmp_curr_addr_done,
  output logic       o_ber_counter_en,
  output logic [1:0] o_state
);

  localparam int CW = $clog2(PRBS_MAX_CYCLES);
  // An all-zero LFSR would lock up, so a zero seed becomes all ones.
  localparam logic [8:0]    SEED_EFF = (SEED == 9'd0) ? 9'h1FF : SEED;
  localparam logic [CW-1:0] LAST     = CW'(PRBS_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_BER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    r_lfsr_q, r_lfsr_d;
  logic [CW-1:0] r_bit_cnt_q, r_bit_cnt_d;
  logic [CW-1:0] r_addr_cnt_q, r_addr_cnt_d;
  logic          soft_reset;
  logic          done;

  assign soft_reset = i_reset | ~i_en_tx;
  assign done       = (state_q == ST_SYNC) && (r_bit_cnt_q == LAST);

  // LFSR next state: free-running shift, with recovery from the lock-up state.
  always_comb begin
    r_lfsr_d = {r_lfsr_q[7:0], r_lfsr_q[8] ^ r_lfsr_q[4]};
    if (r_lfsr_q == 9'd0) begin
      r_lfsr_d = 9'h1FF;
    end
  end

  // Sequencer next state and counter updates (evaluated for a strobe cycle).
  always_comb begin
    state_d      = state_q;
    r_bit_cnt_d  = r_bit_cnt_q;
    r_addr_cnt_d = r_addr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        r_bit_cnt_d  = '0;
        r_addr_cnt_d = '0;
        if (i_start && !i_stop) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (i_stop) begin
          state_d      = ST_IDLE;
          r_bit_cnt_d  = '0;
          r_addr_cnt_d = '0;
        end else if (done) begin
          // Last slot of this candidate: wrap the slot counter and either
          // move to the next candidate or, after the last one, to BER.
          r_bit_cnt_d = '0;
          if (r_addr_cnt_q == LAST) begin
            state_d = ST_BER;
          end else begin
            r_addr_cnt_d = r_addr_cnt_q + CW'(1);
          end
        end else begin
          r_bit_cnt_d = r_bit_cnt_q + CW'(1);
        end
      end
      ST_BER: begin
        if (i_stop) begin
          state_d      = ST_IDLE;
          r_bit_cnt_d  = '0;
          r_addr_cnt_d = '0;
        end else if (i_start) begin
          state_d      = ST_SYNC;
          r_bit_cnt_d  = '0;
          r_addr_cnt_d = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        r_bit_cnt_d  = '0;
        r_addr_cnt_d = '0;
      end
    endcase
  end

  // State register: reset on any clock, otherwise advance only on a strobe.
  always_ff @(posedge clk) begin
    if (soft_reset) begin
      state_q      <= ST_IDLE;
      r_lfsr_q     <= SEED_EFF;
      r_bit_cnt_q  <= '0;
      r_addr_cnt_q <= '0;
    end else if (i_ctrl) begin
      state_q      <= state_d;
      r_lfsr_q     <= r_lfsr_d;
      r_bit_cnt_q  <= r_bit_cnt_d;
      r_addr_cnt_q <= r_addr_cnt_d;
    end
  end

  // Outputs are pure decodes of registers.
  assign o_tx_bit                  = r_lfsr_q[8];
  assign o_new_bit_from_prbs       = r_lfsr_q[8];
  assign o_synchro_en              = (state_q == ST_SYNC);
  assign o_prbs_cmp_curr_addr_done = done;
  assign o_ber_counter_en          = (state_q == ST_BER);
  assign o_state                   = state_q;

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Testbench for prbs_tx_sequencer. A reduced candidate count keeps the full
// sync sequence short; the PRBS itself always has period 511.
module tb_prbs_tx_sequencer;

  localparam int         N        = 13;
  localparam logic [8:0] SEED_V   = 9'h1AA;
  localparam int         PERIOD   = 511;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_en_tx = 1'b1;
  logic       i_ctrl = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       o_tx_bit, o_new_bit_from_prbs, o_synchro_en;
  logic       o_prbs_cmp_curr_addr_done, o_ber_counter_en;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  prbs_tx_sequencer #(.SEED(SEED_V), .PRBS_MAX_CYCLES(N)) dut (
    .clk                       (clk),
    .i_reset                   (i_reset),
    .i_en_tx                   (i_en_tx),
    .i_ctrl                    (i_ctrl),
    .i_start                   (i_start),
    .i_stop                    (i_stop),
    .o_tx_bit                  (o_tx_bit),
    .o_new_bit_from_prbs       (o_new_bit_from_prbs),
    .o_synchro_en              (o_synchro_en),
    .o_prbs_cmp_curr_addr_done (o_prbs_cmp_curr_addr_done),
    .o_ber_counter_en          (o_ber_counter_en),
    .o_state                   (o_state)
  );

  // ---------------- reference model ----------------
  // PRBS as a bit sequence: s[n+9] = s[n] ^ s[n+4], first 9 bits = SEED msb-first.
  // Sequencer as "strobes since SYNC entry" (k): done on k%N == N-1, BER at k == N*N.
  logic prbs_s [0:PERIOD-1];
  int   m_p = 0;     // strobes since reset
  int   m_mode = 0;  // 0 idle, 1 sync, 2 ber
  int   m_k = 0;

  logic [7:0] exp_q[$];   // {record_flag, tx, ref, sync, done, ber, state[1:0]}
  logic       obs_q[$];
  int         total = 0;
  int         bad = 0;

  task automatic build_prbs();
    logic [8:0] sv;
    sv = SEED_V;
    for (int i = 0; i < 9; i++) prbs_s[i] = sv[8-i];
    for (int n = 0; n + 9 < PERIOD; n++) prbs_s[n+9] = prbs_s[n] ^ prbs_s[n+4];
  endtask

  task automatic model_step(input logic ctrl, input logic start, input logic stop,
                            input logic rst);
    if (rst) begin
      m_p = 0; m_mode = 0; m_k = 0;
    end else if (ctrl) begin
      m_p = m_p + 1;
      case (m_mode)
        0: if (start && !stop) begin m_mode = 1; m_k = 0; end
        1: begin
          if (stop) m_mode = 0;
          else begin
            m_k = m_k + 1;
            if (m_k == N * N) m_mode = 2;
          end
        end
        default: begin
          if (stop) m_mode = 0;
          else if (start) begin m_mode = 1; m_k = 0; end
        end
      endcase
    end
  endtask

  function automatic logic [7:0] model_vec(input logic rec);
    logic b, sy, dn, be;
    logic [1:0] st;
    b  = prbs_s[m_p % PERIOD];
    sy = (m_mode == 1);
    dn = (m_mode == 1) && ((m_k % N) == N - 1);
    be = (m_mode == 2);
    st = 2'(m_mode);
    return {rec, b, b, sy, dn, be, st};
  endfunction

  // ---------------- driver ----------------
  // One clock: drive inputs, let the edge happen, queue the expected outputs.
  task automatic drive(input logic ctrl, input logic start, input logic stop,
                       input logic rst, input logic en, input logic rec);
    logic [7:0] e;
    i_ctrl = ctrl; i_start = start; i_stop = stop; i_reset = rst; i_en_tx = en;
    model_step(ctrl, start, stop, rst || !en);
    e = model_vec(rec);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // gap-1 non-strobe clocks with junk start/stop, then one strobe clock.
  task automatic strobe(input logic start, input logic stop, input int gap,
                        input logic rec);
    for (int g = 1; g < gap; g++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    drive(1'b1, start, stop, 1'b0, 1'b1, rec);
  endtask

  task automatic idle_strobes(input int count, input int gap);
    for (int i = 0; i < count; i++) strobe(1'b0, 1'b0, gap, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    logic [6:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {o_tx_bit, o_new_bit_from_prbs, o_synchro_en,
             o_prbs_cmp_curr_addr_done, o_ber_counter_en, o_state};
      total++;
      if (got !== e[6:0]) begin
        bad++;
        $display("FAIL outputs t=%0t got=%b exp=%b (tx,ref,sync,done,ber,state)",
                 $time, got, e[6:0]);
      end
      if (e[7]) obs_q.push_back(o_tx_bit);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones0, ones1, wait_cnt;
    logic [8:0] first9, want9;
    build_prbs();

    // PRBS sequence: reset, then 1022 strobes every 4 clocks.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 1022; i++) strobe(1'b0, 1'b0, 4, 1'b1);

    // Full sync with strobes every 2 clocks, then dwell in BER.
    strobe(1'b1, 1'b0, 2, 1'b0);
    idle_strobes(N * N + 5, 2);

    // Reset mid-BER via i_en_tx=0 with i_ctrl=0.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_strobes(3, 2);

    // Strobe gating in SYNC, with i_ctrl tied 1 around it.
    strobe(1'b1, 1'b0, 1, 1'b0);
    idle_strobes(20, 1);
    for (int i = 0; i < 100; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    idle_strobes(N * N, 1);

    // Reset mid-BER via i_reset=1 with i_ctrl=0.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_strobes(2, 3);

    // Abort at candidate 5, bit 7; restart; then simultaneous start+stop.
    strobe(1'b1, 1'b0, 3, 1'b0);
    idle_strobes(5 * N + 7, 3);
    strobe(1'b0, 1'b1, 3, 1'b0);
    idle_strobes(3, 3);
    strobe(1'b1, 1'b0, 3, 1'b0);
    idle_strobes(2 * N + 2, 3);
    strobe(1'b0, 1'b1, 2, 1'b0);
    strobe(1'b1, 1'b1, 2, 1'b0);
    idle_strobes(4, 2);
    // Start+stop while in BER also returns to IDLE.
    strobe(1'b1, 1'b0, 1, 1'b0);
    idle_strobes(N * N + 2, 1);
    strobe(1'b1, 1'b1, 1, 1'b0);
    idle_strobes(2, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0)
        drive($urandom_range(0, 1) == 1, 1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      else
        strobe($urandom_range(0, 9) == 0, $urandom_range(0, 249) == 0,
               $urandom_range(1, 3), 1'b0);
    end

    // Drain the scoreboard (bounded).
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk); wait_cnt++;
    end
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end

    // PRBS properties on the recorded bits (bit 0 = after reset).
    total++;
    if (obs_q.size() != 1023) begin
      bad++;
      $display("FAIL obs_count got=%0d required=1023", obs_q.size());
    end else begin
      want9 = 9'b110101010;
      for (int i = 0; i < 9; i++) first9[8-i] = obs_q[i];
      total++;
      if (first9 !== want9) begin
        bad++;
        $display("FAIL first9 got=%b required=%b", first9, want9);
      end
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < PERIOD; i++) begin
        ones0 += int'(obs_q[i]);
        ones1 += int'(obs_q[i + PERIOD]);
      end
      total++;
      if (ones0 != 256) begin
        bad++;
        $display("FAIL ones_win0 got=%0d required=256", ones0);
      end
      total++;
      if (ones1 != 256) begin
        bad++;
        $display("FAIL ones_win1 got=%0d required=256", ones1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
